// File: rtl/hex_calc_seq_if.sv
// hex_calc_seq_if: UART byte streams and external adder bus for the hex calculator sequencer
interface hex_calc_seq_if #(parameter int DW = 32);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] add_a;
  logic [DW-1:0] add_b;
  logic          add_cin;
  logic [DW-1:0] add_sum;
  logic          add_cout;
  logic          busy;
  logic          ovf;
  logic          err;
  modport slave (
    input  rx_data, rx_valid, tx_ready, add_sum, add_cout,
    output tx_data, tx_valid, add_a, add_b, add_cin, busy, ovf, err
  );
  modport master (
    output rx_data, rx_valid, tx_ready, add_sum, add_cout,
    input  tx_data, tx_valid, add_a, add_b, add_cin, busy, ovf, err
  );
endinterface

// File: rtl/hex_calc_seq.sv
// hex_calc_seq: parses "A+B=" hex input, runs the external adder once, streams the result as ASCII hex.
// Optional subtract operator '-' is enabled by defining HEX_CALC_SUB_EN.
module hex_calc_seq #(
  parameter int DW     = 32,
  parameter bit OUT_CR = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  hex_calc_seq_if.slave bus
);
  localparam int NDIG = DW / 4;
  localparam int NB   = NDIG + (OUT_CR ? 2 : 0);
  localparam int IW   = $clog2(NB + 1);
`ifdef HEX_CALC_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif
  typedef enum logic [2:0] {A_ENT, B_ENT, CALC1, CALC2, SEND} state_t;
  state_t          state_q, state_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [DW-1:0]   add_a_q, add_a_d, add_b_q, add_b_d;
  logic            a_seen_q, a_seen_d, b_seen_q, b_seen_d, sub_q, sub_d;
  logic            add_cin_q, add_cin_d, ovf_q, ovf_d, err_q, err_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            is_num, is_alpha, is_dig;
  logic [3:0]      nib;
  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
  // Byte i of the reply: digits MSB nibble first, then CR, LF.
  function automatic logic [7:0] out_byte(input logic [DW-1:0] r, input logic [IW-1:0] i);
    int k;
    k = int'(i);
    return (k < NDIG) ? hex_ch(r[4*(NDIG-1-k) +: 4]) : (k == NDIG) ? 8'h0d : 8'h0a;
  endfunction
  // Decode the received byte as a hex digit; letters map to 10..15 by adding 9 to their low nibble.
  always_comb begin
    is_num   = bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39;
    is_alpha = (bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
               (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66);
    is_dig   = is_num || is_alpha;
    nib      = bus.rx_data[3:0] + (is_alpha ? 4'd9 : 4'd0);
  end
  // Next-state logic for the sequencer and all its registered outputs.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    a_seen_d   = a_seen_q;
    b_seen_d   = b_seen_q;
    sub_d      = sub_q;
    res_d      = res_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_cin_d  = add_cin_q;
    ovf_d      = ovf_q;
    err_d      = 1'b0;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    idx_d      = idx_q;
    case (state_q)
      A_ENT, B_ENT: if (bus.rx_valid) begin
        if (bus.rx_data == 8'h1b) begin
          a_d      = '0;
          b_d      = '0;
          a_seen_d = 1'b0;
          b_seen_d = 1'b0;
          state_d  = A_ENT;
        end else if (is_dig && state_q == A_ENT) begin
          a_d      = (a_q << 4) | DW'(nib);
          a_seen_d = 1'b1;
        end else if (is_dig) begin
          b_d      = (b_q << 4) | DW'(nib);
          b_seen_d = 1'b1;
        end else if (state_q == A_ENT && a_seen_q &&
                     (bus.rx_data == 8'h2b || (SUB_EN && bus.rx_data == 8'h2d))) begin
          sub_d   = bus.rx_data == 8'h2d;
          state_d = B_ENT;
        end else if (state_q == B_ENT && b_seen_q && bus.rx_data == 8'h3d) begin
          state_d = CALC1;
        end else begin
          err_d = 1'b1;
        end
      end
      CALC1: begin
        add_a_d   = a_q;
        add_b_d   = sub_q ? ~b_q : b_q;
        add_cin_d = sub_q;
        err_d     = bus.rx_valid;
        state_d   = CALC2;
      end
      CALC2: begin
        res_d      = bus.add_sum;
        ovf_d      = bus.add_cout ^ sub_q;
        tx_valid_d = 1'b1;
        tx_data_d  = out_byte(bus.add_sum, '0);
        idx_d      = '0;
        err_d      = bus.rx_valid;
        state_d    = SEND;
      end
      SEND: begin
        err_d = bus.rx_valid;
        if (tx_valid_q && bus.tx_ready) begin
          if (idx_q == IW'(NB - 1)) begin
            tx_valid_d = 1'b0;
            a_d        = '0;
            b_d        = '0;
            a_seen_d   = 1'b0;
            b_seen_d   = 1'b0;
            state_d    = A_ENT;
          end else begin
            idx_d     = idx_q + 1'b1;
            tx_data_d = out_byte(res_q, idx_q + 1'b1);
          end
        end
      end
      default: state_d = A_ENT;
    endcase
  end
  // State and output registers; reset abandons any reply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= A_ENT;
      a_q        <= '0;
      b_q        <= '0;
      a_seen_q   <= 1'b0;
      b_seen_q   <= 1'b0;
      sub_q      <= 1'b0;
      res_q      <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_cin_q  <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      a_seen_q   <= a_seen_d;
      b_seen_q   <= b_seen_d;
      sub_q      <= sub_d;
      res_q      <= res_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      add_cin_q  <= add_cin_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      idx_q      <= idx_d;
    end
  end
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.add_a    = add_a_q;
  assign bus.add_b    = add_b_q;
  assign bus.add_cin  = add_cin_q;
  assign bus.ovf      = ovf_q;
  assign bus.err      = err_q;
  assign bus.busy     = state_q == CALC1 || state_q == CALC2 || state_q == SEND;
endmodule

// File: tb/tb_hex_calc_seq.sv
// tb_hex_calc_seq: directed vector bench for the hex calculator sequencer with a behavioural adder
module tb_hex_calc_seq;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  hex_calc_seq_if #(.DW(DW)) bus();
  hex_calc_seq #(.DW(DW), .OUT_CR(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{DW{1'b0}}, bus.add_cin};
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    string       in;
    string       dig;
    logic        ovf;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    int          stall;
    bit          lat;
  } vec_t;
  vec_t vecs[$];
  function automatic string vis(string s);
    string r = "";
    for (int i = 0; i < s.len(); i++)
      r = (s[i] == 8'h0d) ? {r, "<CR>"} : (s[i] == 8'h0a) ? {r, "<LF>"} : $sformatf("%s%c", r, s[i]);
    return r;
  endfunction
  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic chk_s(string nm, string got, string exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, vis(got), vis(exp));
    end
  endtask
  task automatic add_vec(string in, string dig, logic ovf, logic [31:0] a, logic [31:0] b,
                         logic cin, int stall, bit lat);
    vec_t v;
    v.in = in; v.dig = dig; v.ovf = ovf; v.a = a; v.b = b; v.cin = cin; v.stall = stall; v.lat = lat;
    vecs.push_back(v);
  endtask
  task automatic send_byte(logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask
  task automatic send_err(string nm, logic [7:0] b, logic e);
    send_byte(b);
    chk({nm, " err"}, bus.err, e);
    @(negedge clk);
    chk({nm, " err low"}, bus.err, 1'b0);
  endtask
  task automatic wait_valid(string nm);
    int c = 0;
    while (bus.tx_valid !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk({nm, " tx_valid timeout"}, bus.tx_valid, 1'b1);
  endtask
  task automatic recv(string nm, string dig, int stall, bit lat);
    string exp, got;
    int cyc, first, held;
    bit stalled_prev, unstable;
    logic [7:0] prev_d;
    exp = $sformatf("%s%c%c", dig, 8'h0d, 8'h0a);
    got = "";
    cyc = 0; first = -1; held = 0; stalled_prev = 0; unstable = 0; prev_d = '0;
    while (got.len() < exp.len() && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.tx_valid === 1'b1 && first < 0) first = cyc;
      if (stalled_prev && (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_d)) unstable = 1;
      stalled_prev = 0;
      if (bus.tx_valid === 1'b1 && held < stall) begin
        bus.tx_ready = 1'b0;
        held++;
        stalled_prev = 1;
        prev_d = bus.tx_data;
      end else if (bus.tx_valid === 1'b1) begin
        bus.tx_ready = 1'b1;
        got = $sformatf("%s%c", got, bus.tx_data);
        held = 0;
      end else begin
        bus.tx_ready = (stall == 0);
      end
    end
    bus.tx_ready = 1'b1;
    chk_s({nm, " reply"}, got, exp);
    if (lat) chk({nm, " latency"}, first, 2);
    if (stall > 0) chk({nm, " stable while stalled"}, unstable, 1'b0);
    @(negedge clk);
    chk({nm, " tx_valid idle"}, bus.tx_valid, 1'b0);
    chk({nm, " busy idle"}, bus.busy, 1'b0);
  endtask
  initial begin
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset tx_valid", bus.tx_valid, 1'b0);
    chk("reset tx_data", bus.tx_data, 8'h00);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset ovf", bus.ovf, 1'b0);
    chk("reset err", bus.err, 1'b0);
    chk("reset add_a", bus.add_a, 32'h0);
    chk("reset add_b", bus.add_b, 32'h0);
    chk("reset add_cin", bus.add_cin, 1'b0);
    rst_n = 1'b1;
    add_vec("1F+1=", "00000020", 1'b0, 32'h1F, 32'h1, 1'b0, 0, 1'b1);
    add_vec("FFFFFFFF+1=", "00000000", 1'b1, 32'hFFFFFFFF, 32'h1, 1'b0, 0, 1'b0);
    add_vec("123456789+1=", "2345678A", 1'b0, 32'h23456789, 32'h1, 1'b0, 0, 1'b0);
    add_vec("1+1=", "00000002", 1'b0, 32'h1, 32'h1, 1'b0, 10, 1'b0);
    add_vec("abcdef01+10101010=", "BBDDFF11", 1'b0, 32'hABCDEF01, 32'h10101010, 1'b0, 0, 1'b0);
    add_vec("80000000+80000000=", "00000000", 1'b1, 32'h80000000, 32'h80000000, 1'b0, 2, 1'b0);
`ifdef HEX_CALC_SUB_EN
    add_vec("5-7=", "FFFFFFFE", 1'b1, 32'h5, 32'hFFFFFFF8, 1'b1, 0, 1'b0);
    add_vec("7-5=", "00000002", 1'b0, 32'h7, 32'hFFFFFFFA, 1'b1, 0, 1'b0);
`endif
    foreach (vecs[i]) begin
      send_str(vecs[i].in);
      recv(vecs[i].in, vecs[i].dig, vecs[i].stall, vecs[i].lat);
      chk({vecs[i].in, " ovf"}, bus.ovf, vecs[i].ovf);
      chk({vecs[i].in, " add_a"}, bus.add_a, vecs[i].a);
      chk({vecs[i].in, " add_b"}, bus.add_b, vecs[i].b);
      chk({vecs[i].in, " add_cin"}, bus.add_cin, vecs[i].cin);
    end
    send_err("plus without A", 8'h2b, 1'b1);
    send_err("G in A", 8'h47, 1'b1);
    send_err("digit 2", 8'h32, 1'b0);
`ifndef HEX_CALC_SUB_EN
    send_err("minus disabled", 8'h2d, 1'b1);
`endif
    send_err("plus", 8'h2b, 1'b0);
    send_err("equals without B", 8'h3d, 1'b1);
    send_err("Z in B", 8'h5a, 1'b1);
    send_str("3=");
    recv("2+3=", "00000005", 0, 1'b0);
    send_str("12+3");
    send_err("ESC", 8'h1b, 1'b0);
    send_str("4+4=");
    recv("ESC then 4+4=", "00000008", 0, 1'b0);
    chk("ESC add_a", bus.add_a, 32'h4);
    bus.tx_ready = 1'b0;
    send_str("5+5=");
    wait_valid("rx in SEND");
    chk("rx in SEND busy", bus.busy, 1'b1);
    send_err("rx in SEND", 8'h37, 1'b1);
    recv("5+5=", "0000000A", 0, 1'b0);
    send_str("9+9=");
    wait_valid("reset mid-SEND");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset mid-SEND tx_valid", bus.tx_valid, 1'b0);
    chk("reset mid-SEND busy", bus.busy, 1'b0);
    chk("reset mid-SEND add_a", bus.add_a, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send_str("1+1=");
    recv("after reset 1+1=", "00000002", 0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
